// File: rtl/crc24a_check.sv
// Byte-serial CRC24A checker: runs the MSB-first CRC over payload plus appended CRC
// and reports one pass/fail result per block (pass = zero remainder, legal length).
module crc24a_check #(
    parameter logic [23:0] POLY      = 24'h864CFB,
    parameter logic [23:0] INIT      = 24'h000000,
    parameter int          CNT_W     = 16,
    parameter int          MIN_BYTES = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_data,
    input  logic             in_last,
    output logic             res_valid,
    input  logic             res_ready,
    output logic             crc_ok,
    output logic             len_err,
    output logic [23:0]      crc_rem,
    output logic [CNT_W-1:0] byte_cnt
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] MIN_CNT = CNT_W'(MIN_BYTES);

    state_t           r_state;
    state_t           w_next_state;
    logic [23:0]      r_rem;
    logic [23:0]      w_rem_next;
    logic [23:0]      w_rem_base;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;
    logic [CNT_W-1:0] w_cnt_base;
    logic             r_in_ready;
    logic             r_res_valid;
    logic             r_crc_ok;
    logic             r_len_err;
    logic [23:0]      r_crc_rem;
    logic [CNT_W-1:0] r_byte_cnt;
    logic             w_xfer;
    logic             w_accept;
    logic             w_enter_done;

    // One byte of the MSB-first shift register, fully unrolled.
    function automatic logic [23:0] crc_byte(input logic [23:0] rem, input logic [7:0] data);
        logic [23:0] v_rem;
        logic        v_fb;
        // NOTE: blocking assignments here are intentional; each bit step feeds the next
        // within the same cycle, whereas registered state below always uses <=.
        v_rem = rem;
        for (int b = 7; b >= 0; b--) begin
            v_fb  = v_rem[23] ^ data[b];
            v_rem = {v_rem[22:0], 1'b0} ^ (v_fb ? POLY : 24'h000000);
        end
        return v_rem;
    endfunction

    assign w_xfer       = in_valid & r_in_ready;
    assign w_accept     = r_res_valid & res_ready;
    assign w_enter_done = (r_state != DONE) && (w_next_state == DONE);

    // A new block always starts from INIT and a zero count, independent of leftovers.
    assign w_rem_base = (r_state == IDLE) ? INIT : r_rem;
    assign w_cnt_base = (r_state == IDLE) ? '0 : r_cnt;

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        w_next_state = r_state;
        w_rem_next   = r_rem;
        w_cnt_next   = r_cnt;
        case (r_state)
            IDLE, RUN: begin
                if (w_xfer) begin
                    w_rem_next   = crc_byte(w_rem_base, in_data);
                    w_cnt_next   = (w_cnt_base == '1) ? w_cnt_base : w_cnt_base + CNT_ONE;
                    w_next_state = in_last ? DONE : RUN;
                end
            end
            DONE: begin
                if (w_accept) begin
                    w_next_state = IDLE;
                    w_rem_next   = INIT;
                    w_cnt_next   = '0;
                end
            end
            default: begin
                w_next_state = IDLE;
                w_rem_next   = INIT;
                w_cnt_next   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_rem       <= INIT;
            r_cnt       <= '0;
            r_in_ready  <= 1'b0;
            r_res_valid <= 1'b0;
            r_crc_ok    <= 1'b0;
            r_len_err   <= 1'b0;
            r_crc_rem   <= 24'h000000;
            r_byte_cnt  <= '0;
        end else begin
            // NOTE: non-blocking assignments keep all registers updating from pre-edge values.
            r_state     <= w_next_state;
            r_rem       <= w_rem_next;
            r_cnt       <= w_cnt_next;
            r_in_ready  <= (w_next_state != DONE);
            r_res_valid <= (w_next_state == DONE);
            if (w_enter_done) begin
                r_crc_rem  <= w_rem_next;
                r_byte_cnt <= w_cnt_next;
                r_len_err  <= (w_cnt_next < MIN_CNT);
                r_crc_ok   <= (w_rem_next == 24'h000000) && (w_cnt_next >= MIN_CNT);
            end
        end
    end

    assign in_ready  = r_in_ready;
    assign res_valid = r_res_valid;
    assign crc_ok    = r_crc_ok;
    assign len_err   = r_len_err;
    assign crc_rem   = r_crc_rem;
    assign byte_cnt  = r_byte_cnt;

endmodule

// File: doc/crc24a_check.md
Name: crc24a_check

Overview:
- Byte-serial CRC24A checker: the receive-side counterpart of the team's crc24a generator.
- Consumes a block of payload bytes followed by its 3 appended CRC bytes, MSB first, and computes the running CRC24A remainder over all bytes.
- Reports pass/fail once per block; pass means a zero final remainder.
- Sits after the byte deframer, ahead of the payload sink, in the LTE transport chain.

Parameters:
- POLY, 24'h864CFB, CRC24A generator polynomial without the implicit x^24 term (full 25-bit form 1100001100100110011111011).
- INIT, 24'h000000, remainder preload at the start of each block.
- CNT_W, 16, width of the byte counter.
- MIN_BYTES, 4, minimum legal block length in bytes (at least 1 payload byte plus 3 CRC bytes).

Ports:
- clk  input  1  system clock; all logic is rising-edge.
- reset  input  1  asynchronous, active-low reset.
- in_valid  input  1  in_data/in_last are valid this cycle.
- in_ready  output  1  checker accepts a byte this cycle.
- in_data  input  8  stream byte; bit 7 is processed first.
- in_last  input  1  marks the final byte of a block, which is the last CRC byte.
- res_valid  output  1  result fields are valid; held until accepted.
- res_ready  input  1  downstream accepts the result.
- crc_ok  output  1  1 = final remainder is zero and the length is legal.
- len_err  output  1  block was shorter than MIN_BYTES.
- crc_rem  output  24  final remainder; for debug and test.
- byte_cnt  output  CNT_W  number of bytes in the block, including the CRC bytes.

Behaviour:
- Reset (reset=0, async):
  - state=IDLE, remainder=INIT, count=0.
  - in_ready=0, res_valid=0, crc_ok=0, len_err=0, crc_rem=0, byte_cnt=0.
- Outputs are registered; a transfer occurs when in_valid&in_ready are both high at a clk edge.
- FSM states: IDLE, RUN, DONE.
  - IDLE: in_ready=1. On the first transfer:
    - remainder = f(INIT, byte), count=1, go to RUN.
    - If in_last is also set, go directly to DONE.
  - RUN: in_ready=1. Each transfer updates remainder = f(rem, byte) and increments count.
    - count saturates at all-ones and does not wrap.
    - A transfer with in_last=1 goes to DONE.
  - DONE: in_ready=0, res_valid=1, result fields hold stable.
    - On res_valid&res_ready, the next state is IDLE, the remainder reloads INIT, and count clears.
    - res_valid drops the cycle after acceptance.
- Update function f: 8 unrolled MSB-first shift steps, all within one cycle. For each bit b from 7 down to 0:
  - fb = rem[23] ^ in_data[b]
  - rem = {rem[22:0],1'b0} ^ (fb ? POLY : 0)
- Throughput and latency:
  - 1 byte per cycle in IDLE/RUN.
  - res_valid rises on the clk edge following the in_last transfer, i.e. 1 cycle after the last byte.
  - Minimum block cycle is N bytes + 1 DONE cycle (with res_ready held high).
- Result fields, latched on entry to DONE:
  - crc_rem = final remainder.
  - byte_cnt = count, including the last byte.
  - len_err = (count < MIN_BYTES).
  - crc_ok = (crc_rem==0) & ~len_err.
- in_valid=0 inserts a bubble: state, remainder and count hold.
- in_data/in_last are ignored when in_valid=0 or in_ready=0.
- No back-to-back overlap: a new block is not accepted until the previous result has been consumed.
- reset asserted mid-block or in DONE: the block is abandoned, no result is emitted, and all outputs return to reset values immediately.
- There is no timeout; a block without in_last stays in RUN indefinitely.

Test Plan:
- Stream ASCII "123456789" (0x31..0x39) then 0xCD,0xE7,0x03 with in_last on 0x03; res_ready=1 -> exactly one res_valid pulse, 1 cycle after the last byte, with crc_ok=1, crc_rem=0, byte_cnt=12, len_err=0.
- Same stream with 0x35 replaced by 0x34 -> crc_ok=0, crc_rem!=0, byte_cnt=12.
- Block 0x01,0x86,0x4C,0xFB (x^24 mod P = 0x864CFB) -> crc_ok=1, byte_cnt=4. Then block 0x00,0x00,0x00 with in_last -> len_err=1, crc_ok=0, crc_rem=0, byte_cnt=3.
- Block from the first test with in_valid deasserted randomly (~40%), and res_ready held 0 for 5 cycles after DONE:
  - in_ready=0 throughout DONE, and a byte offered during DONE is not consumed.
  - Result fields are stable for all 5 cycles.
  - The next block, started right after acceptance, also passes.
- Assert reset for 1 cycle after the 6th byte of the first-test stream, then send the full passing block -> no result from the aborted block; the new block gives crc_ok=1, byte_cnt=12.
